// File: rtl/seq_word_packer.sv
// seq_word_packer
//   Producer side of the 128-bit sequence word. Per-step DAC/PDM values and
//   flags arrive on a valid/ready write port. They are packed into the fixed
//   sequence layout at push time and buffered in a FIFO together with a repeat
//   count and a last marker. One word is played out on seq_data per sequence
//   step.
//
// Parameters
//   DEPTH : FIFO entries (power of two, >= 2)
//   REP_W : repeat-count width
//
// Ports
//   clk, aresetn             : clock, asynchronous active-low reset
//   in_valid / in_ready      : write handshake, push when both high
//   in_dac_0/1 [13:0]        : signed DAC values
//   in_pdm_0..3 [10:0]       : PDM values
//   in_enable_dac, in_resync_dac, in_enable_pdm, in_ramp_down : flags
//   in_repeat [REP_W-1:0]    : extra ticks to hold the entry (0 = one tick)
//   in_last                  : final entry of the sequence
//   start, stop, step_tick   : playout control (stop > start > step_tick)
//   seq_data [127:0]         : registered packed word
//   busy                     : state is not IDLE
//   done                     : one-cycle pulse when the last entry completes
//   underrun                 : sticky, cleared by start
//   fill_level               : registered FIFO occupancy
//
// Configuration macro
//   SEQ_PACKER_UNDERRUN_SAFE_EN : on underrun, emit a ramp-down word that keeps
//   only enable_dac, flush the FIFO and return to IDLE. When undefined, the
//   current word is held and the block waits in STARVED.

module seq_word_packer #(
  parameter int DEPTH = 16,
  parameter int REP_W = 16
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [13:0]              in_dac_0,
  input  logic [13:0]              in_dac_1,
  input  logic [10:0]              in_pdm_0,
  input  logic [10:0]              in_pdm_1,
  input  logic [10:0]              in_pdm_2,
  input  logic [10:0]              in_pdm_3,
  input  logic [1:0]               in_enable_dac,
  input  logic [1:0]               in_resync_dac,
  input  logic [3:0]               in_enable_pdm,
  input  logic [1:0]               in_ramp_down,
  input  logic [REP_W-1:0]         in_repeat,
  input  logic                     in_last,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     step_tick,
  output logic [127:0]             seq_data,
  output logic                     busy,
  output logic                     done,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   fill_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 128 + REP_W + 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, STARVED} state_t;

  state_t state, state_nxt;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [127:0]     in_word, head_word;
  logic [REP_W-1:0] head_rep, rep_cnt;
  logic             head_last, cur_last;
  logic             fifo_empty, push, pop, flush, clear_word, dec_rep;
  logic             done_nxt, set_underrun, clr_underrun;
`ifdef SEQ_PACKER_UNDERRUN_SAFE_EN
  logic             safe_load;
  logic [127:0]     safe_word;
`endif

  assign fifo_empty = (count == '0);
  assign in_ready   = (count != FULL_CNT);
  assign fill_level = count;
  assign busy       = (state != IDLE);
  assign {head_last, head_rep, head_word} = mem[rd_ptr];

  // A flush (stop, or a safe underrun) wins over a simultaneous write.
  assign push = in_valid && in_ready && !flush;

  // Fixed sequence-word layout; every unlisted bit stays 0.
  always_comb begin
    in_word          = '0;
    in_word[13:0]    = in_dac_0;
    in_word[29:16]   = in_dac_1;
    in_word[31:30]   = in_resync_dac;
    in_word[42:32]   = in_pdm_0;
    in_word[58:48]   = in_pdm_1;
    in_word[74:64]   = in_pdm_2;
    in_word[90:80]   = in_pdm_3;
    in_word[97:96]   = in_enable_dac;
    in_word[101:98]  = in_enable_pdm;
    in_word[113:112] = in_ramp_down;
  end

`ifdef SEQ_PACKER_UNDERRUN_SAFE_EN
  // Ramp-down word: keep the DAC enables, force both ramp_down bits.
  always_comb begin
    safe_word          = '0;
    safe_word[97:96]   = seq_data[97:96];
    safe_word[113:112] = 2'b11;
  end
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_last, in_repeat, in_word};
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start && !fifo_empty) state_nxt = RUN;
        RUN:     if (step_tick && rep_cnt == '0) begin
                   if (cur_last) state_nxt = IDLE;
                   else if (fifo_empty)
`ifdef SEQ_PACKER_UNDERRUN_SAFE_EN
                     state_nxt = IDLE;
`else
                     state_nxt = STARVED;
`endif
                 end
        STARVED: if (step_tick && !fifo_empty) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Every pop loads the popped entry into seq_data/rep_cnt in the same cycle.
  always_comb begin
    pop          = 1'b0;
    flush        = 1'b0;
    clear_word   = 1'b0;
    dec_rep      = 1'b0;
    done_nxt     = 1'b0;
    set_underrun = 1'b0;
    clr_underrun = 1'b0;
`ifdef SEQ_PACKER_UNDERRUN_SAFE_EN
    safe_load    = 1'b0;
`endif
    if (stop) begin
      clear_word = 1'b1;
      flush      = 1'b1;
    end else begin
      case (state)
        IDLE: if (start && !fifo_empty) begin
          pop          = 1'b1;
          clr_underrun = 1'b1;
        end
        RUN: if (step_tick) begin
          if (rep_cnt != '0) begin
            dec_rep = 1'b1;
          end else if (cur_last) begin
            clear_word = 1'b1;
            done_nxt   = 1'b1;
          end else if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            set_underrun = 1'b1;
`ifdef SEQ_PACKER_UNDERRUN_SAFE_EN
            safe_load = 1'b1;
            flush     = 1'b1;
`endif
          end
        end
        STARVED: if (step_tick && !fifo_empty) pop = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      seq_data <= '0;
      rep_cnt  <= '0;
      cur_last <= 1'b0;
      done     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      done <= done_nxt;
      if (clear_word)     seq_data <= '0;
`ifdef SEQ_PACKER_UNDERRUN_SAFE_EN
      else if (safe_load) seq_data <= safe_word;
`endif
      else if (pop)       seq_data <= head_word;
      if (pop) begin
        rep_cnt  <= head_rep;
        cur_last <= head_last;
      end else if (dec_rep) begin
        rep_cnt <= rep_cnt - 1'b1;
      end
      if (clr_underrun)      underrun <= 1'b0;
      else if (set_underrun) underrun <= 1'b1;
    end
  end

endmodule

// File: doc/seq_word_packer.md
# seq_word_packer

Producer side of the 128-bit sequence word consumed by the sequence slice decoder. Accepts per-step DAC/PDM values and flags over a valid/ready write port, packs them into the fixed 128-bit sequence layout, buffers them in a FIFO, and presents one word on `seq_data` per sequence step, with a per-entry repeat count. It sits between the sequence loader (host/DMA side) and the sequence slice decoder.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, at least 2.
- `REP_W`, 16, repeat-count width.
- `clk` in 1: system clock.
- `aresetn` in 1: asynchronous active-low reset.
- `in_valid` in 1: write entry valid.
- `in_ready` out 1: FIFO can accept an entry.
- `in_dac_0`, `in_dac_1` in 14 each: signed DAC values.
- `in_pdm_0` … `in_pdm_3` in 11 each: PDM values.
- `in_enable_dac` in 2, `in_resync_dac` in 2, `in_enable_pdm` in 4, `in_ramp_down` in 2: flags.
- `in_repeat` in REP_W: extra ticks to hold the entry; 0 means hold for 1 tick.
- `in_last` in 1: final entry of the sequence.
- `start` in 1: begin playout.
- `stop` in 1: abort playout and flush the FIFO.
- `step_tick` in 1: one-cycle sequence step strobe.
- `seq_data` out 128: registered packed word.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse when the last entry completes.
- `underrun` out 1: sticky flag; cleared by `start`.
- `fill_level` out $clog2(DEPTH)+1: registered FIFO occupancy.

## Operation
- Packing layout, applied at push time. Every bit not listed below is 0.
  - [13:0] dac_0, [29:16] dac_1, [31:30] resync_dac.
  - [42:32] pdm_0, [58:48] pdm_1, [74:64] pdm_2, [90:80] pdm_3.
  - [97:96] enable_dac, [101:98] enable_pdm, [112] ramp_down[0], [113] ramp_down[1].
- The FIFO stores the packed word plus repeat and last, i.e. 128+REP_W+1 bits per entry.
- Push occurs when `in_valid && in_ready`. `in_ready = (fill_level != DEPTH)`. There is no push-to-output bypass.
- States: IDLE, RUN, STARVED.
- IDLE
  - `start` with FIFO non-empty: pop, load `seq_data`, load `rep_cnt` = repeat, clear `underrun`, go to RUN.
  - `start` with FIFO empty: ignored.
- RUN, on `step_tick`:
  - `rep_cnt` != 0: decrement `rep_cnt` and hold the word.
  - `rep_cnt` == 0 and current entry is last: `seq_data` <= 0, pulse `done`, go to IDLE.
  - `rep_cnt` == 0, not last, FIFO non-empty: pop the next entry.
  - `rep_cnt` == 0, not last, FIFO empty: set `underrun`, take the underrun action (see Configuration).
- STARVED: hold `seq_data`. On `step_tick` with FIFO non-empty, pop and return to RUN. Popping stays aligned to the tick grid.
- `stop`, in any state: `seq_data` <= 0, FIFO flushed (`fill_level` <= 0), go to IDLE. No `done` pulse.
- Priority: `stop` > `start` > `step_tick`. `start` in RUN or STARVED is ignored.
- A push and a pop in the same cycle leave `fill_level` unchanged.

## Timing
- Reset values: `seq_data` = 0, `in_ready` = 1, `busy` = 0, `done` = 0, `underrun` = 0, `fill_level` = 0, state IDLE.
- Push visible in `fill_level` 1 cycle later.
- `start` at cycle N: first word on `seq_data` at N+1, `busy` = 1 at N+1.
- `step_tick` at cycle N that advances the sequence: new word at N+1.
- An entry with repeat R stays on `seq_data` for R+1 step ticks.
- `done` is high at the cycle after the final tick, together with `seq_data` = 0.
- `stop` at cycle N: outputs at their reset values at N+1, except `underrun`, which holds its value.

## Configuration
- `SEQ_PACKER_UNDERRUN_SAFE_EN` defined:
  - On underrun, `seq_data` <= word with only bits [97:96] copied from the current word and bits [113:112] = 2'b11.
  - State goes to IDLE and the FIFO is flushed.
  - Downstream DACs ramp down.
- Undefined:
  - On underrun, the current word is held and the state goes to STARVED.

## Test plan
- Reset, push 3 entries (dac_0 = 14'h1FFF, dac_1 = 14'h2000, pdm_0 = 11'h7FF, repeat 0, last on the 3rd), `start`, 3 ticks:
  - `seq_data` bits [13:0] = 0x1FFF, [29:16] = 0x2000, [42:32] = 0x7FF.
  - All unlisted bits 0; `done` pulses after tick 3 and `seq_data` = 0.
- Entry with repeat 4, then a last entry: first word held for exactly 5 ticks; second word appears the cycle after tick 5.
- Push DEPTH entries without `start`: `in_ready` = 0 and `fill_level` = DEPTH; a further `in_valid` is not accepted. Then push and pop in the same cycle: `fill_level` stays DEPTH-1.
- Two non-last entries, `start`, 2 ticks:
  - Safe macro undefined: `underrun` = 1, state STARVED, word 2 held. A push followed by a tick pops the new word.
  - Safe macro defined: `seq_data` = bits 113:112 set plus the copied enable_dac bits, `busy` = 0.
- `stop` asserted in the same cycle as `step_tick` and `in_valid` during RUN: next cycle `seq_data` = 0, `fill_level` = 0, `busy` = 0.
- Assert `aresetn` low mid-RUN for 1 cycle, asynchronously: all outputs return to reset values immediately.
